// File: rtl/hpu_palette_stage.sv
// hpu_palette_stage: 32-entry RGB565 palette, reloaded from video memory at every vblank and after reset.
// Define HPU_PAL_BACKDROP_EN to make colour index 0 of every palette show entry 0.
module hpu_palette_stage #(
    parameter logic [15:0] PAL_BASE = 16'h2AC0,
    parameter int          ACTIVE_W = 800,
    parameter int          ACTIVE_H = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  true_line,
    input  logic [9:0]  true_column,
    input  logic [4:0]  pixel_in,
    output logic [15:0] addr_out,
    input  logic [7:0]  data_in,
    output logic [15:0] rgb_out,
    output logic        de_out,
    output logic        pal_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE_LO, ISSUE_HI, CAPTURE} state_t;
    localparam logic [9:0] W10 = 10'(ACTIVE_W);
    localparam logic [9:0] H10 = 10'(ACTIVE_H);
    state_t      state;
    logic [4:0]  idx;
    logic [7:0]  lo_byte;
    logic        boot;
    logic [15:0] pal [32];
    logic        active;
    logic        trigger;
    logic [4:0]  sel;
    logic [15:0] entry_addr;
    assign active     = (true_column < W10) && (true_line < H10);
    assign trigger    = (true_line == H10) && (true_column == 10'd0);
    assign entry_addr = PAL_BASE + {10'd0, idx, 1'b0};
`ifdef HPU_PAL_BACKDROP_EN
    assign sel = (pixel_in[2:0] == 3'd0) ? 5'd0 : pixel_in;
`else
    assign sel = pixel_in;
`endif
    // boot forces a load on the first cycle out of reset without waiting for vblank
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            addr_out <= '0;
            lo_byte  <= '0;
            pal_busy <= 1'b0;
            boot     <= 1'b1;
            rgb_out  <= '0;
            de_out   <= 1'b0;
            for (int i = 0; i < 32; i++) pal[i] <= '0;
        end else begin
            rgb_out <= active ? pal[sel] : 16'h0000;
            de_out  <= active;
            case (state)
                IDLE: if (boot || trigger) begin
                    state    <= ISSUE_LO;
                    idx      <= '0;
                    addr_out <= PAL_BASE;
                    pal_busy <= 1'b1;
                    boot     <= 1'b0;
                end
                ISSUE_LO: begin
                    state    <= ISSUE_HI;
                    addr_out <= entry_addr + 16'd1;
                end
                ISSUE_HI: begin
                    state   <= CAPTURE;
                    lo_byte <= data_in;
                end
                CAPTURE: begin
                    pal[idx] <= {data_in, lo_byte};
                    if (idx == 5'd31) begin
                        state    <= IDLE;
                        pal_busy <= 1'b0;
                    end else begin
                        state    <= ISSUE_LO;
                        idx      <= idx + 5'd1;
                        addr_out <= entry_addr + 16'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hpu_palette_stage.sv
// tb_hpu_palette_stage: randomized self-checking bench for hpu_palette_stage against a memory-derived palette model.
module tb_hpu_palette_stage;
    localparam logic [15:0] BASE = 16'h2AC0;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  true_line = '0;
    logic [9:0]  true_column = '0;
    logic [4:0]  pixel_in = '0;
    logic [7:0]  data_in = '0;
    logic [15:0] addr_out;
    logic [15:0] rgb_out;
    logic        de_out;
    logic        pal_busy;
    logic [7:0]  mem [65536];
    int          total = 0;
    int          passed = 0;

    hpu_palette_stage dut (
        .clk(clk), .reset(reset), .true_line(true_line), .true_column(true_column),
        .pixel_in(pixel_in), .addr_out(addr_out), .data_in(data_in),
        .rgb_out(rgb_out), .de_out(de_out), .pal_busy(pal_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) data_in <= mem[addr_out];

    function automatic logic [15:0] entry(input int k);
        return {mem[16'(BASE + 2 * k + 1)], mem[16'(BASE + 2 * k)]};
    endfunction

    function automatic logic [15:0] lookup(input logic [4:0] pix);
`ifdef HPU_PAL_BACKDROP_EN
        if (pix[2:0] == 3'd0) return entry(0);
`endif
        return entry(int'(pix));
    endfunction

    function automatic logic [15:0] fetch_addr(input int c);
        return 16'(BASE + 2 * (c / 3) + ((c % 3 != 0) ? 1 : 0));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++; if (rgb_out !== 16'h0) $display("FAIL reset_rgb got %h want 0000", rgb_out); else passed++;
        total++; if (de_out !== 1'b0) $display("FAIL reset_de got %b want 0", de_out); else passed++;
        total++; if (addr_out !== 16'h0) $display("FAIL reset_addr got %h want 0000", addr_out); else passed++;
        total++; if (pal_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", pal_busy); else passed++;
    endtask

    task automatic test_load();
        true_line = 10'd0; true_column = 10'd1; pixel_in = 5'd0;
        reset = 1'b1;
        for (int c = 0; c <= 96; c++) begin
            step();
            total++; if (pal_busy !== (c < 96)) $display("FAIL load_busy c=%0d got %b want %b", c, pal_busy, c < 96); else passed++;
            if (c < 96) begin
                total++; if (addr_out !== fetch_addr(c)) $display("FAIL load_addr c=%0d got %h want %h", c, addr_out, fetch_addr(c)); else passed++;
            end
        end
        pixel_in = 5'd3;
        step();
        total++; if (rgb_out !== 16'h0706) $display("FAIL load_pal3 got %h want 0706", rgb_out); else passed++;
        for (int p = 0; p < 32; p++) begin
            pixel_in = 5'(p);
            step();
            total++; if (rgb_out !== lookup(5'(p))) $display("FAIL load_lookup p=%0d got %h want %h", p, rgb_out, lookup(5'(p))); else passed++;
        end
    endtask

    task automatic test_active_window();
        logic [9:0] ls [6] = '{10'd10, 10'd479, 10'd0,   10'd500, 10'd480, 10'd479};
        logic [9:0] cs [6] = '{10'd100, 10'd799, 10'd800, 10'd0,  10'd5,   10'd1023};
        for (int i = 0; i < 46; i++) begin
            logic act;
            if (i < 6) begin
                true_line = ls[i]; true_column = cs[i];
                pixel_in = (i == 0) ? 5'b01_011 : 5'($urandom);
            end else begin
                true_line = 10'($urandom_range(0, 600));
                true_column = 10'($urandom_range(0, 1023));
                if (true_line == 10'd480 && true_column == 10'd0) true_column = 10'd1;
                pixel_in = 5'($urandom);
            end
            act = (true_line < 10'd480) && (true_column < 10'd800);
            step();
            total++; if (de_out !== act) $display("FAIL window_de i=%0d got %b want %b", i, de_out, act); else passed++;
            total++; if (rgb_out !== (act ? lookup(pixel_in) : 16'h0)) $display("FAIL window_rgb i=%0d got %h want %h", i, rgb_out, act ? lookup(pixel_in) : 16'h0); else passed++;
        end
        true_line = 10'd0; true_column = 10'd1;
    endtask

    task automatic test_backdrop();
        int n;
        for (int i = 0; i < 64; i++) mem[16'(BASE + i)] = 8'(i);
        mem[16'h2AF0] = 8'hAA;
        true_line = 10'd480; true_column = 10'd0;
        step();
        true_line = 10'd0; true_column = 10'd1;
        n = 0;
        while (pal_busy === 1'b1 && n < 200) begin step(); n++; end
        total++; if (pal_busy !== 1'b0) $display("FAIL backdrop_reload_timeout got busy=%b want 0", pal_busy); else passed++;
        pixel_in = 5'b11_000;
        step();
`ifdef HPU_PAL_BACKDROP_EN
        total++; if (rgb_out !== 16'h0100) $display("FAIL backdrop_24 got %h want 0100", rgb_out); else passed++;
`else
        total++; if (rgb_out !== 16'h31AA) $display("FAIL backdrop_24 got %h want 31aa", rgb_out); else passed++;
`endif
        pixel_in = 5'b01_000;
        step();
        total++; if (rgb_out !== lookup(5'b01_000)) $display("FAIL backdrop_8 got %h want %h", rgb_out, lookup(5'b01_000)); else passed++;
    endtask

    task automatic test_vblank_retrigger();
        for (int i = 0; i < 64; i++) mem[16'(BASE + i)] = 8'($urandom);
        true_line = 10'd480; true_column = 10'd0;
        for (int c = 0; c <= 96; c++) begin
            step();
            if (c == 0 || c == 21) begin true_line = 10'd0; true_column = 10'd1; end
            if (c == 20) begin true_line = 10'd480; true_column = 10'd0; end
            total++; if (pal_busy !== (c < 96)) $display("FAIL retrig_busy c=%0d got %b want %b", c, pal_busy, c < 96); else passed++;
            if (c < 96) begin
                total++; if (addr_out !== fetch_addr(c)) $display("FAIL retrig_addr c=%0d got %h want %h", c, addr_out, fetch_addr(c)); else passed++;
            end
        end
        for (int p = 0; p < 32; p++) begin
            pixel_in = 5'(p);
            step();
            total++; if (rgb_out !== lookup(5'(p))) $display("FAIL retrig_lookup p=%0d got %h want %h", p, rgb_out, lookup(5'(p))); else passed++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        for (int i = 0; i < 64; i++) mem[16'(BASE + i)] = 8'($urandom);
        true_line = 10'd480; true_column = 10'd0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c == 0) begin true_line = 10'd0; true_column = 10'd1; end
        end
        reset = 1'b0; pixel_in = 5'd31;
        step();
        total++; if (pal_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", pal_busy); else passed++;
        total++; if (addr_out !== 16'h0) $display("FAIL midrst_addr got %h want 0000", addr_out); else passed++;
        total++; if (de_out !== 1'b0 || rgb_out !== 16'h0) $display("FAIL midrst_out got de=%b rgb=%h want 0/0000", de_out, rgb_out); else passed++;
        reset = 1'b1;
        for (int c = 0; c <= 97; c++) begin
            step();
            total++; if (pal_busy !== (c < 96)) $display("FAIL midrst_restart_busy c=%0d got %b want %b", c, pal_busy, c < 96); else passed++;
            if (c < 96) begin
                total++; if (addr_out !== fetch_addr(c)) $display("FAIL midrst_restart_addr c=%0d got %h want %h", c, addr_out, fetch_addr(c)); else passed++;
            end
            total++; if (rgb_out !== ((c <= 96) ? 16'h0 : entry(31))) $display("FAIL midrst_entry31 c=%0d got %h want %h", c, rgb_out, (c <= 96) ? 16'h0 : entry(31)); else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) mem[16'(BASE + i)] = 8'(i);
        test_reset();
        test_load();
        test_active_window();
        test_backdrop();
        test_vblank_retrigger();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
